// File: rtl/oponente_auto_pkg.sv
// Shared definitions for the automatic Y player: FSM states, the line cell table,
// the fallback cell preference order and small board helpers.
package oponente_auto_pkg;

  localparam int unsigned N_CELULAS = 9;
  localparam int unsigned N_LINHAS  = 8;

  typedef logic [0:8]      tabuleiro_t;
  typedef logic [3:0]      celula_t;
  typedef logic [0:2][3:0] linha_t;

  typedef enum logic [2:0] {
    ESPERA_X,
    BUSCA_VITORIA,
    BUSCA_BLOQUEIO,
    ESCOLHE_FIXA,
    ATRASO,
    GRAVA,
    FIM
  } estado_t;

  // Rows, then columns, then the two diagonals.
  function automatic linha_t celulas_linha(input logic [2:0] linha);
    linha_t t;
    case (linha)
      3'd0:    t = {4'd0, 4'd1, 4'd2};
      3'd1:    t = {4'd3, 4'd4, 4'd5};
      3'd2:    t = {4'd6, 4'd7, 4'd8};
      3'd3:    t = {4'd0, 4'd3, 4'd6};
      3'd4:    t = {4'd1, 4'd4, 4'd7};
      3'd5:    t = {4'd2, 4'd5, 4'd8};
      3'd6:    t = {4'd0, 4'd4, 4'd8};
      default: t = {4'd2, 4'd4, 4'd6};
    endcase
    return t;
  endfunction

  function automatic celula_t ordem_fixa(input logic [3:0] i);
    celula_t c;
    case (i)
      4'd0:    c = 4'd4;
      4'd1:    c = 4'd0;
      4'd2:    c = 4'd2;
      4'd3:    c = 4'd6;
      4'd4:    c = 4'd8;
      4'd5:    c = 4'd1;
      4'd6:    c = 4'd3;
      4'd7:    c = 4'd5;
      default: c = 4'd7;
    endcase
    return c;
  endfunction

  // Bit 4 flags a free cell was found; bits 3:0 carry that cell.
  function automatic logic [4:0] primeira_livre(input tabuleiro_t ocupado);
    logic [4:0] r;
    celula_t    c;
    r = '0;
    for (int unsigned i = 0; i < N_CELULAS; i++) begin
      c = ordem_fixa(4'(i));
      if (!r[4] && !ocupado[c]) r = {1'b1, c};
    end
    return r;
  endfunction

  function automatic logic [3:0] conta_bits(input tabuleiro_t v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < N_CELULAS; i++) n = n + 4'(v[i]);
    return n;
  endfunction

endpackage

// File: rtl/oponente_auto_if.sv
// Board exchange between the game and the automatic Y player.
interface oponente_auto_if;
  import oponente_auto_pkg::*;

  tabuleiro_t posicaoX;
  logic       vencedor;
  tabuleiro_t posicaoY;
  logic       jogada_valida;
  logic       erro;

  modport master (
    input  posicaoX, vencedor,
    output posicaoY, jogada_valida, erro
  );

  modport slave (
    output posicaoX, vencedor,
    input  posicaoY, jogada_valida, erro
  );
endinterface

// File: rtl/oponente_auto_linha_avalia.sv
// Combinational evaluation of one board line: X/Y cell counts and first empty cell.
module linha_avalia
  import oponente_auto_pkg::*;
(
  input  tabuleiro_t i_x,
  input  tabuleiro_t i_y,
  input  logic [2:0] i_linha,
  output logic [1:0] o_cnt_x,
  output logic [1:0] o_cnt_y,
  output celula_t    o_vazia,
  output logic       o_tem_vazia
);
  linha_t w_cel;

  always_comb begin
    w_cel       = celulas_linha(i_linha);
    o_cnt_x     = '0;
    o_cnt_y     = '0;
    o_vazia     = '0;
    o_tem_vazia = 1'b0;
    for (int unsigned k = 0; k < 3; k++) begin
      if (i_x[w_cel[k]]) begin
        o_cnt_x = o_cnt_x + 2'd1;
      end else if (i_y[w_cel[k]]) begin
        o_cnt_y = o_cnt_y + 2'd1;
      end else if (!o_tem_vazia) begin
        o_vazia     = w_cel[k];
        o_tem_vazia = 1'b1;
      end
    end
  end
endmodule

// File: rtl/oponente_auto.sv
// Automatic tic-tac-toe player Y: answers each legal X move with a win, a block,
// or the first free cell of a fixed preference order, via a one-line-per-cycle scan.
module oponente_auto
  import oponente_auto_pkg::*;
#(
  parameter bit          Y_FIRST      = 1'b0,
  parameter int unsigned DELAY_CYCLES = 2
) (
  input logic            clock,
  input logic            reset,
  oponente_auto_if.master jogo
);
  localparam bit         SEM_ATRASO = (DELAY_CYCLES == 0);
  localparam logic [3:0] ULT_ATRASO = SEM_ATRASO ? 4'd0 : 4'(DELAY_CYCLES - 1);

  estado_t    r_state, w_state;
  logic [3:0] r_idx, w_idx;
  logic [3:0] r_cnt, w_cnt;
  celula_t    r_cell, w_cell;
  tabuleiro_t r_xprev, w_xprev;
  tabuleiro_t r_posy, w_posy;
  logic       r_jv, w_jv;
  logic       r_erro, w_erro;

  tabuleiro_t w_novo, w_limpo;
  logic [1:0] w_cnt_x, w_cnt_y;
  celula_t    w_vazia;
  logic       w_tem_vazia;
  logic [4:0] w_fixa;
  estado_t    w_pos_escolha;

  linha_avalia u_linha (
    .i_x        (r_xprev),
    .i_y        (r_posy),
    .i_linha    (r_idx[2:0]),
    .o_cnt_x    (w_cnt_x),
    .o_cnt_y    (w_cnt_y),
    .o_vazia    (w_vazia),
    .o_tem_vazia(w_tem_vazia)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= Y_FIRST ? ESCOLHE_FIXA : ESPERA_X;
      r_idx   <= '0;
      r_cnt   <= '0;
      r_cell  <= '0;
      r_xprev <= '0;
      r_posy  <= '0;
      r_jv    <= 1'b0;
      r_erro  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_idx   <= w_idx;
      r_cnt   <= w_cnt;
      r_cell  <= w_cell;
      r_xprev <= w_xprev;
      r_posy  <= w_posy;
      r_jv    <= w_jv;
      r_erro  <= w_erro;
    end
  end

  always_comb begin
    w_state       = r_state;
    w_idx         = r_idx;
    w_cnt         = r_cnt;
    w_cell        = r_cell;
    w_xprev       = r_xprev;
    w_posy        = r_posy;
    w_jv          = 1'b0;
    w_erro        = r_erro;
    w_novo        = jogo.posicaoX & ~r_xprev;
    w_limpo       = r_xprev & ~jogo.posicaoX;
    w_fixa        = primeira_livre(r_xprev | r_posy);
    w_pos_escolha = SEM_ATRASO ? GRAVA : ATRASO;

    if (r_state == FIM) begin
      w_state = FIM;
    end else if (jogo.vencedor) begin
      w_state = FIM;
    end else if (r_state == ESPERA_X) begin
      if (jogo.posicaoX != r_xprev) begin
        if (conta_bits(w_novo) == 4'd1 && w_limpo == '0 && (w_novo & r_posy) == '0) begin
          w_xprev = jogo.posicaoX;
          w_idx   = '0;
          w_state = BUSCA_VITORIA;
        end else begin
          w_erro  = 1'b1;
          w_state = FIM;
        end
      end
    end else if (jogo.posicaoX != r_xprev) begin
      w_erro  = 1'b1;
      w_state = FIM;
    end else begin
      case (r_state)
        BUSCA_VITORIA: begin
          if (w_cnt_y == 2'd2 && w_cnt_x == 2'd0 && w_tem_vazia) begin
            w_cell  = w_vazia;
            w_cnt   = '0;
            w_state = w_pos_escolha;
          end else if (r_idx == 4'(N_LINHAS - 1)) begin
            w_idx   = '0;
            w_state = BUSCA_BLOQUEIO;
          end else begin
            w_idx = r_idx + 4'd1;
          end
        end
        // Index N_LINHAS is a closing cycle after the last line before falling back.
        BUSCA_BLOQUEIO: begin
          if (r_idx == 4'(N_LINHAS)) begin
            w_state = ESCOLHE_FIXA;
          end else if (w_cnt_x == 2'd2 && w_cnt_y == 2'd0 && w_tem_vazia) begin
            w_cell  = w_vazia;
            w_cnt   = '0;
            w_state = w_pos_escolha;
          end else begin
            w_idx = r_idx + 4'd1;
          end
        end
        ESCOLHE_FIXA: begin
          if (w_fixa[4]) begin
            w_cell  = w_fixa[3:0];
            w_cnt   = '0;
            w_state = w_pos_escolha;
          end else begin
            w_state = FIM;
          end
        end
        ATRASO: begin
          if (r_cnt == ULT_ATRASO) w_state = GRAVA;
          else                     w_cnt   = r_cnt + 4'd1;
        end
        GRAVA: begin
          w_posy[r_cell] = 1'b1;
          w_jv           = 1'b1;
          w_state        = ESPERA_X;
        end
        default: w_state = FIM;
      endcase
    end
  end

  assign jogo.posicaoY      = r_posy;
  assign jogo.jogada_valida = r_jv;
  assign jogo.erro          = r_erro;
endmodule
